store_commit_buffer: RTL and testbench
======================================

STORE_COMMIT_BUFFER -- requirements
Module: store_commit_buffer

Interface
REQ-001 Parameter: DEPTH, default 8, number of entries; SHALL be a power of two, minimum 2.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 cpu_clock_i  in  1  sole clock; all state updates on its rising edge.
REQ-004 cpu_reset_n_i  in  1  asynchronous, active-low reset.
REQ-005 enq_valid_i  in  1  committed store offered by the LSU commit port.
REQ-006 enq_ready_o  out  1  buffer accepts the store this cycle.
REQ-007 enq_address_i  in  30  word address (byte address [31:2]).
REQ-008 enq_data_i  in  32  store data, byte-lane aligned.
REQ-009 enq_bm_i  in  4  byte mask.
REQ-010 store_valid_o  out  1  head entry presented to the dcache store port.
REQ-011 store_address_o  out  30  head word address.
REQ-012 store_data_o  out  32  head data.
REQ-013 store_bm_o  out  4  head byte mask.
REQ-014 cache_done_i  in  1  dcache store-complete pulse.
REQ-015 load_chk_address_i  in  30  word address of a load being issued.
REQ-016 load_chk_bm_i  in  4  byte mask of that load.
REQ-017 load_conflict_o  out  1  load overlaps a pending store; the load stalls.
REQ-018 empty_o  out  1  no entries pending; used by fence and CMO sequencing.

Function
REQ-019 The buffer SHALL be a circular FIFO of DEPTH entries {address, data, bm}, with head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-020 The occupancy count SHALL be $clog2(DEPTH)+1 bits wide.
REQ-021 enq_ready_o SHALL equal (count != DEPTH), so a full buffer accepts nothing even if a pop occurs in the same cycle.
REQ-022 Coalescing: an accepted store SHALL merge into the youngest entry instead of allocating when all of the following hold: count >= 2, youngest address == enq_address_i, and youngest is not head.
REQ-023 Merge rule: per byte lane, new data overwrites where enq_bm_i is set; bm becomes old bm | enq_bm_i.
REQ-024 A merge SHALL NOT change count.
REQ-025 Drain: store_valid_o SHALL be (count != 0) and SHALL be driven from registered entry state; latency from enqueue into an empty buffer to store_valid_o is 1 cycle.
REQ-026 While store_valid_o is high, the head outputs SHALL remain stable until the cycle in which cache_done_i is high.
REQ-027 On cache_done_i with count != 0, the head SHALL pop: head advances, count decrements.
REQ-028 The next entry SHALL then be presented on the following cycle, which is when the dcache re-enters IDLE.
REQ-029 cache_done_i while empty SHALL be ignored.
REQ-030 Simultaneous allocating enqueue and pop SHALL leave count unchanged.
REQ-031 Simultaneous merging enqueue and pop SHALL decrement count.
REQ-032 load_conflict_o SHALL be combinational: OR over valid entries of (address == load_chk_address_i) & |(bm & load_chk_bm_i).
REQ-033 load_conflict_o SHALL include the head while it is in flight.
REQ-034 load_conflict_o SHALL NOT consider the same-cycle enqueue.
REQ-035 empty_o SHALL equal (count == 0).

Reset
REQ-036 On cpu_reset_n_i low, asynchronously: head = tail = count = 0; store_valid_o = 0; empty_o = 1; enq_ready_o = 1; load_conflict_o = 0.
REQ-037 Entry data and address need not be reset.
REQ-038 Reset mid-drain SHALL discard all entries, including an in-flight head; the dcache is reset by the same signal.
REQ-039 After reset deassertion, an enqueue is accepted on the first edge.

Structure
REQ-040 The entry struct typedef (address [29:0], data [31:0], bm [3:0]) and the default DEPTH constant SHALL live in the shared memory-system package.
REQ-041 The overlap comparator array SHALL be one sub-module, store_conflict_cam, instantiated once.
REQ-042 The remaining logic SHALL be a single flat always_ff plus combinational merge logic.

Verification
REQ-043 Enqueue {0x0000100, 0xDEADBEEF, 0xF} into an empty buffer -> store_valid_o high next cycle with those values; hold 5 cycles; cache_done_i pulse -> empty_o = 1 next cycle.
REQ-044 With DEPTH = 8: enqueue 8 distinct addresses with no cache_done_i -> enq_ready_o = 0; a 9th enq_valid_i together with cache_done_i is not accepted; the next cycle accepts it (count stays 8).
REQ-045 Head at A = 0x10 in flight, youngest B = 0x20 {0x000000AA, 0x1}; enqueue B {0x0000BB00, 0x2} -> count unchanged; B drains as {0x0000BBAA, 0x3}.
REQ-046 Count 1, head A in flight; enqueue A again -> allocates a new entry (no merge into head); count = 2.
REQ-047 Pending store {0x40, bm 0xC}: load 0x40 with bm 0x3 -> load_conflict_o = 0; load 0x40 with bm 0x4 -> load_conflict_o = 1; load 0x41 with bm 0xF -> load_conflict_o = 0.
REQ-048 Assert cpu_reset_n_i low mid-drain with 3 entries -> store_valid_o = 0 asynchronously and empty_o = 1; after release, a new store drains normally; pointer wrap is checked over 20 enqueue/pop pairs.

Source files
------------

// File: rtl/store_commit_buffer_pkg.sv
// ----------------------------------------------------------------------------
// store_commit_buffer_pkg
//
// Shared memory-system definitions used by the store commit buffer and its
// conflict comparator array.
//
// Contents:
//   SB_DEPTH_DEFAULT : default number of store buffer entries
//   SB_ADDR_W        : word address width (byte address [31:2])
//   SB_DATA_W        : store data width
//   SB_BM_W          : byte mask width
//   sb_entry_t       : one buffered store {address, data, bm}
//   sb_merge()       : byte-lane merge of a younger store into an entry
// ----------------------------------------------------------------------------
package store_commit_buffer_pkg;

    localparam int unsigned SB_DEPTH_DEFAULT = 8;
    localparam int unsigned SB_ADDR_W        = 30;
    localparam int unsigned SB_DATA_W        = 32;
    localparam int unsigned SB_BM_W          = 4;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] address;
        logic [SB_DATA_W-1:0] data;
        logic [SB_BM_W-1:0]   bm;
    } sb_entry_t;

    // A younger store to the same word wins on every lane it writes; lanes it
    // does not touch keep the older data. The merged mask covers both stores.
    function automatic sb_entry_t sb_merge(input sb_entry_t             old_entry,
                                           input logic [SB_DATA_W-1:0] new_data,
                                           input logic [SB_BM_W-1:0]   new_bm);
        sb_entry_t merged;
        merged = old_entry;
        for (int lane = 0; lane < int'(SB_BM_W); lane++) begin
            if (new_bm[lane]) begin
                merged.data[8*lane +: 8] = new_data[8*lane +: 8];
            end
        end
        merged.bm = old_entry.bm | new_bm;
        return merged;
    endfunction

endpackage

// File: rtl/store_commit_buffer_conflict_cam.sv
// ----------------------------------------------------------------------------
// store_conflict_cam
//
// Purely combinational overlap detector. Flags a load whose word address
// matches any valid buffered store and whose byte mask shares at least one
// lane with that store.
//
// Ports:
//   entries_i      in  DEPTH x sb_entry_t  buffer contents, indexed by slot
//   valid_i        in  DEPTH               slot holds a pending store
//   load_address_i in  30                  word address of the issuing load
//   load_bm_i      in  4                   byte mask of the issuing load
//   conflict_o     out 1                   load overlaps a pending store
// ----------------------------------------------------------------------------
module store_conflict_cam
    import store_commit_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH_DEFAULT
) (
    input  sb_entry_t            entries_i [DEPTH],
    input  logic [DEPTH-1:0]     valid_i,
    input  logic [SB_ADDR_W-1:0] load_address_i,
    input  logic [SB_BM_W-1:0]   load_bm_i,
    output logic                 conflict_o
);

    logic [DEPTH-1:0] hit_vec;

    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            hit_vec[i] = valid_i[i]
                       && (entries_i[i].address == load_address_i)
                       && (|(entries_i[i].bm & load_bm_i));
        end
        conflict_o = |hit_vec;
    end

endmodule

// File: rtl/store_commit_buffer.sv
// ----------------------------------------------------------------------------
// store_commit_buffer
//
// Circular FIFO holding committed stores between the LSU commit port and the
// dcache store port. A store to the same word as the youngest pending entry
// is coalesced into it, unless that entry is the head (already presented to
// the dcache). Loads are checked against every pending store, including the
// head while it is in flight.
//
// Ports:
//   cpu_clock_i        in  1   clock, rising edge
//   cpu_reset_n_i      in  1   asynchronous active-low reset
//   enq_valid_i        in  1   committed store offered
//   enq_ready_o        out 1   store accepted this cycle
//   enq_address_i      in  30  store word address
//   enq_data_i         in  32  store data, lane aligned
//   enq_bm_i           in  4   store byte mask
//   store_valid_o      out 1   head entry presented to the dcache
//   store_address_o    out 30  head word address
//   store_data_o       out 32  head data
//   store_bm_o         out 4   head byte mask
//   cache_done_i       in  1   dcache store-complete pulse
//   load_chk_address_i in  30  word address of a load being issued
//   load_chk_bm_i      in  4   byte mask of that load
//   load_conflict_o    out 1   load overlaps a pending store
//   empty_o            out 1   nothing pending
//
// DEPTH must be a power of two and at least 2 so that the pointers wrap by
// plain binary overflow.
// ----------------------------------------------------------------------------
module store_commit_buffer
    import store_commit_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH_DEFAULT
) (
    input  logic                 cpu_clock_i,
    input  logic                 cpu_reset_n_i,
    input  logic                 enq_valid_i,
    output logic                 enq_ready_o,
    input  logic [SB_ADDR_W-1:0] enq_address_i,
    input  logic [SB_DATA_W-1:0] enq_data_i,
    input  logic [SB_BM_W-1:0]   enq_bm_i,
    output logic                 store_valid_o,
    output logic [SB_ADDR_W-1:0] store_address_o,
    output logic [SB_DATA_W-1:0] store_data_o,
    output logic [SB_BM_W-1:0]   store_bm_o,
    input  logic                 cache_done_i,
    input  logic [SB_ADDR_W-1:0] load_chk_address_i,
    input  logic [SB_BM_W-1:0]   load_chk_bm_i,
    output logic                 load_conflict_o,
    output logic                 empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    sb_entry_t        entry_q [DEPTH];
    sb_entry_t        entry_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [PTR_W-1:0] youngest_idx;
    logic             enq_fire;
    logic             merge_hit;
    logic             alloc;
    logic             pop;
    logic [DEPTH-1:0] slot_valid;

    // Readiness looks only at the registered count, so a full buffer turns
    // away a store even when the head pops in the same cycle.
    assign enq_ready_o = (count_q != CNT_W'(DEPTH));
    assign empty_o     = (count_q == '0);

    // Head outputs come straight from registered state; the head slot is
    // never the merge target, so they hold steady until cache_done_i.
    assign store_valid_o   = (count_q != '0);
    assign store_address_o = entry_q[head_q].address;
    assign store_data_o    = entry_q[head_q].data;
    assign store_bm_o      = entry_q[head_q].bm;

    // Next-state computation for pointers, count and entry storage.
    // With count >= 2 the youngest slot cannot be the head, which is what
    // keeps an in-flight store from being modified by a merge.
    always_comb begin
        entry_d      = entry_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        youngest_idx = tail_q - PTR_W'(1);
        enq_fire     = enq_valid_i && enq_ready_o;
        merge_hit    = enq_fire
                    && (count_q >= CNT_W'(2))
                    && (entry_q[youngest_idx].address == enq_address_i);
        alloc        = enq_fire && !merge_hit;
        pop          = cache_done_i && (count_q != '0);

        if (merge_hit) begin
            entry_d[youngest_idx] = sb_merge(entry_q[youngest_idx], enq_data_i, enq_bm_i);
        end

        if (alloc) begin
            entry_d[tail_q] = '{address: enq_address_i, data: enq_data_i, bm: enq_bm_i};
            tail_d          = tail_q + PTR_W'(1);
        end

        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end

        count_d = count_q + CNT_W'(alloc) - CNT_W'(pop);
    end

    // A slot is live when its distance from the head, modulo DEPTH, is less
    // than the occupancy count.
    always_comb begin
        slot_valid = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            slot_valid[i] = ({1'b0, PTR_W'(i) - head_q} < count_q);
        end
    end

    // All buffer state in one register process; entries are cleared on reset
    // too so that simulation never shows X on the idle head outputs.
    always_ff @(posedge cpu_clock_i or negedge cpu_reset_n_i) begin
        if (!cpu_reset_n_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            entry_q <= entry_d;
        end
    end

    store_conflict_cam #(
        .DEPTH (DEPTH)
    ) u_conflict_cam (
        .entries_i      (entry_q),
        .valid_i        (slot_valid),
        .load_address_i (load_chk_address_i),
        .load_bm_i      (load_chk_bm_i),
        .conflict_o     (load_conflict_o)
    );

endmodule

// File: tb/tb_store_commit_buffer.sv
// ----------------------------------------------------------------------------
// tb_store_commit_buffer
//
// Directed scenarios followed by a randomized phase. A queue-based reference
// model of the buffer predicts every output each cycle before the clock edge.
// ----------------------------------------------------------------------------
module tb_store_commit_buffer;

    localparam int DEPTH = 8;

    logic        cpu_clock_i = 1'b0;
    logic        cpu_reset_n_i;
    logic        enq_valid_i;
    logic        enq_ready_o;
    logic [29:0] enq_address_i;
    logic [31:0] enq_data_i;
    logic [3:0]  enq_bm_i;
    logic        store_valid_o;
    logic [29:0] store_address_o;
    logic [31:0] store_data_o;
    logic [3:0]  store_bm_o;
    logic        cache_done_i;
    logic [29:0] load_chk_address_i;
    logic [3:0]  load_chk_bm_i;
    logic        load_conflict_o;
    logic        empty_o;

    int compareCount = 0;
    int failCount    = 0;

    typedef struct {
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  bm;
    } model_entry_t;

    model_entry_t modelQ[$];

    always #5 cpu_clock_i = ~cpu_clock_i;

    store_commit_buffer #(
        .DEPTH (DEPTH)
    ) dut (
        .cpu_clock_i        (cpu_clock_i),
        .cpu_reset_n_i      (cpu_reset_n_i),
        .enq_valid_i        (enq_valid_i),
        .enq_ready_o        (enq_ready_o),
        .enq_address_i      (enq_address_i),
        .enq_data_i         (enq_data_i),
        .enq_bm_i           (enq_bm_i),
        .store_valid_o      (store_valid_o),
        .store_address_o    (store_address_o),
        .store_data_o       (store_data_o),
        .store_bm_o         (store_bm_o),
        .cache_done_i       (cache_done_i),
        .load_chk_address_i (load_chk_address_i),
        .load_chk_bm_i      (load_chk_bm_i),
        .load_conflict_o    (load_conflict_o),
        .empty_o            (empty_o)
    );

    // One comparison: counts it, and on disagreement reports and counts a failure.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Any pending store at the same word sharing a byte lane blocks the load.
    function automatic logic modelConflict(input logic [29:0] ldAddr, input logic [3:0] ldBm);
        foreach (modelQ[i]) begin
            if (modelQ[i].addr == ldAddr && (modelQ[i].bm & ldBm) != 4'h0) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Compare every output against the model state before the coming edge.
    task automatic checkAllOutputs(input string tag);
        checkOutput({tag, ".ready"}, 32'(enq_ready_o), 32'(modelQ.size() != DEPTH));
        checkOutput({tag, ".valid"}, 32'(store_valid_o), 32'(modelQ.size() != 0));
        checkOutput({tag, ".empty"}, 32'(empty_o), 32'(modelQ.size() == 0));
        checkOutput({tag, ".conflict"}, 32'(load_conflict_o),
                    32'(modelConflict(load_chk_address_i, load_chk_bm_i)));
        if (modelQ.size() != 0) begin
            checkOutput({tag, ".addr"}, 32'(store_address_o), 32'(modelQ[0].addr));
            checkOutput({tag, ".data"}, store_data_o, modelQ[0].data);
            checkOutput({tag, ".bm"}, 32'(store_bm_o), 32'(modelQ[0].bm));
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic modelAdvance();
        int           sz;
        logic [31:0]  laneMask;
        model_entry_t e;
        sz = modelQ.size();
        if (enq_valid_i && sz != DEPTH) begin
            if (sz >= 2 && modelQ[sz-1].addr == enq_address_i) begin
                laneMask = {{8{enq_bm_i[3]}}, {8{enq_bm_i[2]}}, {8{enq_bm_i[1]}}, {8{enq_bm_i[0]}}};
                e = modelQ[sz-1];
                e.data = (e.data & ~laneMask) | (enq_data_i & laneMask);
                e.bm   = e.bm | enq_bm_i;
                modelQ[sz-1] = e;
            end else begin
                modelQ.push_back('{addr: enq_address_i, data: enq_data_i, bm: enq_bm_i});
            end
        end
        if (cache_done_i && sz != 0) begin
            void'(modelQ.pop_front());
        end
    endtask

    // Drive one cycle of inputs just after a falling edge, check, then clock.
    task automatic applyStimulus(input string tag, input logic enqV, input logic [29:0] addr,
                                 input logic [31:0] data, input logic [3:0] bm,
                                 input logic done, input logic [29:0] ldAddr,
                                 input logic [3:0] ldBm);
        enq_valid_i        = enqV;
        enq_address_i      = addr;
        enq_data_i         = data;
        enq_bm_i           = bm;
        cache_done_i       = done;
        load_chk_address_i = ldAddr;
        load_chk_bm_i      = ldBm;
        #1;
        checkAllOutputs(tag);
        modelAdvance();
        @(posedge cpu_clock_i);
        @(negedge cpu_clock_i);
    endtask

    task automatic idleCycle(input string tag, input logic done);
        applyStimulus(tag, 1'b0, 30'h0, 32'h0, 4'h0, done, 30'h0, 4'h0);
    endtask

    initial begin
        cpu_reset_n_i      = 1'b0;
        enq_valid_i        = 1'b0;
        enq_address_i      = '0;
        enq_data_i         = '0;
        enq_bm_i           = '0;
        cache_done_i       = 1'b0;
        load_chk_address_i = '0;
        load_chk_bm_i      = 4'hF;

        // Reset state
        #2;
        checkAllOutputs("reset");
        @(negedge cpu_clock_i);
        cpu_reset_n_i = 1'b1;

        // Single store into empty buffer, accepted on first edge after reset
        applyStimulus("single_enq", 1'b1, 30'h100, 32'hDEADBEEF, 4'hF, 1'b0, 30'h0, 4'h0);
        #1;
        checkOutput("single_valid", 32'(store_valid_o), 32'h1);
        checkOutput("single_addr", 32'(store_address_o), 32'h100);
        checkOutput("single_data", store_data_o, 32'hDEADBEEF);
        for (int i = 0; i < 5; i++) idleCycle("single_hold", 1'b0);
        idleCycle("single_done", 1'b1);
        #1;
        checkOutput("single_empty_after", 32'(empty_o), 32'h1);

        // cache_done_i while empty is ignored
        idleCycle("done_empty", 1'b1);
        idleCycle("done_empty_after", 1'b0);

        // Fill to DEPTH, full buffer refuses even with a concurrent pop
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus("fill", 1'b1, 30'h200 + 30'(i), 32'h1000 + 32'(i), 4'hF, 1'b0, 30'h203, 4'h1);
        end
        #1;
        checkOutput("full_ready", 32'(enq_ready_o), 32'h0);
        applyStimulus("full_pop", 1'b1, 30'h300, 32'hCAFE0009, 4'hF, 1'b1, 30'h300, 4'hF);
        applyStimulus("refill", 1'b1, 30'h300, 32'hCAFE0009, 4'hF, 1'b0, 30'h300, 4'hF);
        #1;
        checkOutput("refill_ready", 32'(enq_ready_o), 32'h0);
        for (int i = 0; i < DEPTH; i++) idleCycle("fill_drain", 1'b1);

        // Same address as the in-flight head allocates a new entry
        applyStimulus("head_a", 1'b1, 30'h10, 32'h11111111, 4'hF, 1'b0, 30'h10, 4'h1);
        applyStimulus("head_a_again", 1'b1, 30'h10, 32'h22222222, 4'h3, 1'b0, 30'h10, 4'h1);
        idleCycle("head_hold", 1'b1);
        #1;
        checkOutput("no_merge_second", store_data_o, 32'h22222222);
        idleCycle("head_drain", 1'b1);

        // Coalescing into the youngest, non-head entry
        applyStimulus("co_a", 1'b1, 30'h10, 32'h12345678, 4'hF, 1'b0, 30'h20, 4'h3);
        applyStimulus("co_b", 1'b1, 30'h20, 32'h000000AA, 4'h1, 1'b0, 30'h20, 4'h3);
        applyStimulus("co_b_merge", 1'b1, 30'h20, 32'h0000BB00, 4'h2, 1'b0, 30'h20, 4'h2);
        idleCycle("co_pop_a", 1'b1);
        #1;
        checkOutput("co_merged_data", store_data_o, 32'h0000BBAA);
        checkOutput("co_merged_bm", 32'(store_bm_o), 32'h3);
        idleCycle("co_pop_b", 1'b1);

        // Load conflict lanes and address
        applyStimulus("ld_enq", 1'b1, 30'h40, 32'hAABB0000, 4'hC, 1'b0, 30'h40, 4'hC);
        applyStimulus("ld_lo", 1'b0, 30'h0, 32'h0, 4'h0, 1'b0, 30'h40, 4'h3);
        applyStimulus("ld_b2", 1'b0, 30'h0, 32'h0, 4'h0, 1'b0, 30'h40, 4'h4);
        applyStimulus("ld_other", 1'b0, 30'h0, 32'h0, 4'h0, 1'b0, 30'h41, 4'hF);
        load_chk_address_i = 30'h40;
        load_chk_bm_i      = 4'h4;
        #1;
        checkOutput("ld_b2_direct", 32'(load_conflict_o), 32'h1);
        idleCycle("ld_drain", 1'b1);

        // Reset mid-drain with three entries
        for (int i = 0; i < 3; i++) begin
            applyStimulus("mid_fill", 1'b1, 30'h600 + 30'(i), 32'h600 + 32'(i), 4'hF, 1'b0, 30'h600, 4'hF);
        end
        idleCycle("mid_drain", 1'b1);
        #2;
        cpu_reset_n_i = 1'b0;
        cache_done_i  = 1'b0;
        modelQ.delete();
        #1;
        checkOutput("mid_rst_valid", 32'(store_valid_o), 32'h0);
        checkOutput("mid_rst_empty", 32'(empty_o), 32'h1);
        checkAllOutputs("mid_rst");
        @(negedge cpu_clock_i);
        cpu_reset_n_i = 1'b1;

        // Pointer wrap over 20 enqueue/pop pairs
        applyStimulus("wrap_first", 1'b1, 30'h700, 32'h70000000, 4'hF, 1'b0, 30'h700, 4'hF);
        for (int i = 1; i <= 20; i++) begin
            applyStimulus("wrap", 1'b1, 30'h700 + 30'(i), 32'h70000000 + 32'(i), 4'hF, 1'b1,
                          30'h700 + 30'(i), 4'hF);
        end
        idleCycle("wrap_last", 1'b1);

        // Randomized traffic on a small address set for merges and conflicts
        for (int i = 0; i < 400; i++) begin
            applyStimulus("rand",
                          ($urandom_range(0, 99) < 60),
                          30'h500 + 30'($urandom_range(0, 3)),
                          $urandom,
                          4'($urandom_range(1, 15)),
                          ($urandom_range(0, 99) < 40),
                          30'h500 + 30'($urandom_range(0, 3)),
                          4'($urandom_range(0, 15)));
        end
        for (int i = 0; i < DEPTH + 1; i++) idleCycle("final_drain", 1'b1);
        idleCycle("final_empty", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
